// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: instruction handshake plus counter control/readback between the sequencer and its environment
interface pc_seq_ctrl_if #(
  parameter int AW = 10
);
  logic          start;
  logic          instr_valid;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic          flag_z;
  logic [AW-1:0] pc;
  logic          instr_req;
  logic          en;
  logic          load;
  logic          updn;
  logic [AW-1:0] data_in;
  logic          halted;
  logic          stk_err;
  modport master (
    input  start, instr_valid, opcode, operand, flag_z, pc,
    output instr_req, en, load, updn, data_in, halted, stk_err
  );
  modport slave (
    output start, instr_valid, opcode, operand, flag_z, pc,
    input  instr_req, en, load, updn, data_in, halted, stk_err
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch/decode sequencer driving the program counter with a return-address stack.
// Define PC_SEQ_ILLEGAL_TRAP_EN to trap opcodes 7-15 into ERR instead of treating them as NOP.
module pc_seq_ctrl #(
  parameter int AW = 10,
  parameter int STK_DEPTH = 4
) (
  input logic clk5m,
  input logic rst,
  pc_seq_ctrl_if.master io_bus
);
  localparam int SPW = $clog2(STK_DEPTH + 1);
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [3:0] OP_JMP = 4'd1, OP_JZ = 4'd2, OP_CALL = 4'd3, OP_RET = 4'd4, OP_SKIP = 4'd5, OP_HALT = 4'd6;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, SKIP2, HALT, ERR} state_t;
  state_t r_state, w_nxt;
  logic [3:0] r_op;
  logic [SPW-1:0] r_sp, w_top;
  logic [AW-1:0] r_stk [2**SPW];
  logic [AW-1:0] r_data, w_data;
  logic r_en, r_load, r_req, r_halted, r_err;
  logic w_en, w_load, w_full, w_empty, w_push, w_pop;
  assign w_full = r_sp == SPW'(STK_DEPTH);
  assign w_empty = r_sp == '0;
  assign w_top = r_sp - SPW'(1);
  assign w_push = r_state == EXEC && r_op == OP_CALL && !w_full;
  assign w_pop = r_state == EXEC && r_op == OP_RET && !w_empty;
  // Strobes are decoded while the instruction is accepted so they leave a register in the EXEC cycle.
  always_comb begin
    w_nxt = r_state;
    w_en = 1'b0;
    w_load = 1'b0;
    w_data = '0;
    case (r_state)
      IDLE, HALT: w_nxt = io_bus.start ? FETCH : r_state;
      FETCH: if (io_bus.instr_valid) begin
        w_nxt = EXEC;
        case (io_bus.opcode)
          OP_JMP: w_load = 1'b1;
          OP_JZ: begin
            w_load = io_bus.flag_z;
            w_en = !io_bus.flag_z;
          end
          OP_CALL: w_load = !w_full;
          OP_RET: w_load = !w_empty;
          OP_SKIP: w_en = 1'b1;
          OP_HALT: ;
          default: w_en = !(TRAP && io_bus.opcode > 4'd6);
        endcase
        w_data = w_load ? (io_bus.opcode == OP_RET ? r_stk[w_top] : io_bus.operand) : '0;
      end
      EXEC: case (r_op)
        OP_CALL: w_nxt = w_full ? ERR : FETCH;
        OP_RET: w_nxt = w_empty ? ERR : FETCH;
        OP_SKIP: begin
          w_nxt = SKIP2;
          w_en = 1'b1;
        end
        OP_HALT: w_nxt = HALT;
        default: w_nxt = (TRAP && r_op > 4'd6) ? ERR : FETCH;
      endcase
      SKIP2: w_nxt = FETCH;
      default: ;
    endcase
  end
  always_ff @(posedge clk5m) begin
    if (rst) begin
      r_state <= IDLE;
      r_op <= '0;
      r_sp <= '0;
      r_en <= 1'b0;
      r_load <= 1'b0;
      r_data <= '0;
      r_req <= 1'b0;
      r_halted <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_en <= w_en;
      r_load <= w_load;
      r_data <= w_data;
      r_req <= w_nxt == FETCH;
      r_halted <= w_nxt == HALT;
      r_err <= w_nxt == ERR;
      if (r_state == FETCH && io_bus.instr_valid) r_op <= io_bus.opcode;
      if (w_push) r_sp <= r_sp + SPW'(1);
      if (w_pop) r_sp <= w_top;
    end
  end
  // Return address is taken in EXEC, before the counter moves to the call target.
  always_ff @(posedge clk5m) begin
    if (!rst && w_push) r_stk[r_sp] <= io_bus.pc + AW'(1);
  end
  assign io_bus.instr_req = r_req;
  assign io_bus.en = r_en;
  assign io_bus.load = r_load;
  assign io_bus.updn = 1'b0;
  assign io_bus.data_in = r_data;
  assign io_bus.halted = r_halted;
  assign io_bus.stk_err = r_err;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed and random instruction streams checked cycle by cycle against a trace model.
module tb_pc_seq_ctrl;
  localparam int AW = 10;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct packed {logic en; logic load; logic [AW-1:0] data; logic req; logic halted; logic err;} rec_t;
  typedef enum int {M_IDLE, M_FETCH, M_HALT, M_ERR} mode_t;
  logic clk5m = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  pc_seq_ctrl_if #(.AW(AW)) io_bus();
  pc_seq_ctrl #(.AW(AW), .STK_DEPTH(DEPTH)) dut (.clk5m(clk5m), .rst(rst), .io_bus(io_bus));
  always #100 clk5m = ~clk5m;
  // Counter stand-in; the bench can also preset it directly.
  logic [AW-1:0] cnt = '0;
  logic [AW-1:0] set_val = '0;
  logic set_req = 1'b0;
  assign io_bus.pc = cnt;
  always @(posedge clk5m)
    cnt <= set_req ? set_val : io_bus.load ? io_bus.data_in : io_bus.en ? cnt + AW'(1) : cnt;
  // Reference model: each accepted instruction expands into the list of cycles it must produce.
  rec_t sched[$];
  rec_t exp_r = '0;
  mode_t mode = M_IDLE;
  logic [AW-1:0] stk[$];
  logic [AW-1:0] mpc = '0;
  bit was_sched = 1'b0;
  bit armed = 1'b0;
  function automatic rec_t mk(input bit e, input bit l, input logic [AW-1:0] d);
    rec_t r = '0;
    r.en = e;
    r.load = l;
    r.data = d;
    return r;
  endfunction
  function automatic rec_t steady(input mode_t m);
    rec_t r = '0;
    r.req = m == M_FETCH;
    r.halted = m == M_HALT;
    r.err = m == M_ERR;
    return r;
  endfunction
  function automatic void accept(input logic [3:0] op, input logic [AW-1:0] opnd, input logic fz);
    logic [AW-1:0] d;
    case (op)
      4'd1: begin sched.push_back(mk(0, 1, opnd)); mpc = opnd; end
      4'd2: begin sched.push_back(fz ? mk(0, 1, opnd) : mk(1, 0, '0)); mpc = fz ? opnd : mpc + AW'(1); end
      4'd3:
        if (stk.size() == DEPTH) begin sched.push_back(mk(0, 0, '0)); mode = M_ERR; end
        else begin stk.push_back(mpc + AW'(1)); sched.push_back(mk(0, 1, opnd)); mpc = opnd; end
      4'd4:
        if (stk.size() == 0) begin sched.push_back(mk(0, 0, '0)); mode = M_ERR; end
        else begin d = stk.pop_back(); sched.push_back(mk(0, 1, d)); mpc = d; end
      4'd5: begin sched.push_back(mk(1, 0, '0)); sched.push_back(mk(1, 0, '0)); mpc = mpc + AW'(2); end
      4'd6: begin sched.push_back(mk(0, 0, '0)); mode = M_HALT; end
      default:
        if (TRAP) begin sched.push_back(mk(0, 0, '0)); mode = M_ERR; end
        else begin sched.push_back(mk(1, 0, '0)); mpc = mpc + AW'(1); end
    endcase
  endfunction
  always @(posedge clk5m) begin
    if (rst) begin
      mode = M_IDLE;
      stk.delete();
      sched.delete();
      exp_r = '0;
      was_sched = 1'b0;
      armed = 1'b1;
    end else begin
      if (set_req) mpc = set_val;
      if (sched.size() == 0 && !was_sched) begin
        if ((mode == M_IDLE || mode == M_HALT) && io_bus.start) mode = M_FETCH;
        else if (mode == M_FETCH && io_bus.instr_valid) accept(io_bus.opcode, io_bus.operand, io_bus.flag_z);
      end
      was_sched = sched.size() != 0;
      exp_r = was_sched ? sched.pop_front() : steady(mode);
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req_v, $time);
  endtask
  always @(negedge clk5m) begin
    if (armed) begin
      check("cycle", {io_bus.en, io_bus.load, io_bus.data_in, io_bus.instr_req, io_bus.halted, io_bus.stk_err, io_bus.updn},
            {exp_r, 1'b0});
      if (exp_r.req && !rst) check("pc", 32'(io_bus.pc), 32'(mpc));
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk5m);
    rst = 1'b0;
  endtask
  task automatic set_pc(input logic [AW-1:0] v);
    set_req = 1'b1;
    set_val = v;
    @(negedge clk5m);
    set_req = 1'b0;
  endtask
  task automatic pulse_start();
    io_bus.start = 1'b1;
    @(negedge clk5m);
    io_bus.start = 1'b0;
  endtask
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] opnd, input logic fz);
    int k = 0;
    while (!io_bus.instr_req && k < 20) begin
      @(negedge clk5m);
      k++;
    end
    if (!io_bus.instr_req) begin
      check("req_timeout", 32'(io_bus.instr_req), 32'd1);
      return;
    end
    io_bus.instr_valid = 1'b1;
    io_bus.opcode = op;
    io_bus.operand = opnd;
    io_bus.flag_z = fz;
    io_bus.start = 1'($urandom_range(0, 1));
    @(negedge clk5m);
    io_bus.instr_valid = 1'b0;
    io_bus.opcode = 4'($urandom);
    io_bus.operand = AW'($urandom);
    io_bus.flag_z = 1'($urandom);
    io_bus.start = 1'b0;
  endtask
  initial begin
    #(200 * 40000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    io_bus.start = 1'b0;
    io_bus.instr_valid = 1'b0;
    io_bus.opcode = '0;
    io_bus.operand = '0;
    io_bus.flag_z = 1'b0;
    @(negedge clk5m);
    do_reset();
    check("rst_out", {io_bus.en, io_bus.load, io_bus.data_in, io_bus.instr_req, io_bus.halted, io_bus.stk_err, io_bus.updn}, 32'd0);
    set_pc(10'd5);
    pulse_start();
    issue(4'd0, 10'h3C7, 1'b0);
    check("nop_strb", {io_bus.en, io_bus.load, io_bus.updn, io_bus.instr_req}, 4'b1000);
    @(negedge clk5m);
    check("nop_next", {io_bus.instr_req, io_bus.en}, 2'b10);
    check("nop_pc", 32'(io_bus.pc), 32'd6);
    set_pc(10'd3);
    issue(4'd2, 10'h2A, 1'b1);
    check("jz_taken", {io_bus.load, io_bus.en, io_bus.data_in}, {2'b10, 10'h2A});
    @(negedge clk5m);
    check("jz_taken_pc", {io_bus.load, io_bus.data_in, io_bus.pc}, {11'd0, 10'h2A});
    set_pc(10'd3);
    issue(4'd2, 10'h2A, 1'b0);
    check("jz_not", {io_bus.load, io_bus.en, io_bus.data_in}, {2'b01, 10'h0});
    @(negedge clk5m);
    check("jz_not_pc", 32'(io_bus.pc), 32'd4);
    set_pc(10'h010);
    issue(4'd3, 10'h100, 1'b0);
    check("call_load", {io_bus.load, io_bus.data_in}, {1'b1, 10'h100});
    @(negedge clk5m);
    check("call_pc", 32'(io_bus.pc), 32'h100);
    issue(4'd4, 10'h2F0, 1'b0);
    check("ret_load", {io_bus.load, io_bus.data_in}, {1'b1, 10'h011});
    @(negedge clk5m);
    set_pc(10'd1023);
    issue(4'd3, 10'h055, 1'b0);
    @(negedge clk5m);
    issue(4'd4, 10'h2F0, 1'b0);
    check("ret_wrap", {io_bus.load, io_bus.data_in}, {1'b1, 10'h000});
    @(negedge clk5m);
    set_pc(10'd1022);
    issue(4'd5, 10'h0, 1'b0);
    check("skip_en1", {io_bus.en, io_bus.load}, 2'b10);
    @(negedge clk5m);
    check("skip_en2", {io_bus.en, io_bus.load}, 2'b10);
    @(negedge clk5m);
    check("skip_done", {io_bus.en, io_bus.instr_req, io_bus.pc}, {2'b01, 10'd0});
    issue(4'd6, 10'h0, 1'b0);
    check("halt_exec", {io_bus.en, io_bus.load, io_bus.instr_req}, 3'b000);
    @(negedge clk5m);
    check("halt_state", {io_bus.halted, io_bus.instr_req, io_bus.en, io_bus.load}, 4'b1000);
    pulse_start();
    check("halt_resume", {io_bus.halted, io_bus.instr_req}, 2'b01);
    issue(4'd9, 10'h0, 1'b0);
    check("op9_en", 32'(io_bus.en), 32'(!TRAP));
    @(negedge clk5m);
    check("op9_err", 32'(io_bus.stk_err), 32'(TRAP));
    do_reset();
    set_pc(10'd0);
    pulse_start();
    repeat (DEPTH) begin
      issue(4'd3, AW'($urandom), 1'b0);
      @(negedge clk5m);
    end
    issue(4'd3, 10'h3FF, 1'b0);
    check("ovf_strb", {io_bus.en, io_bus.load}, 2'b00);
    @(negedge clk5m);
    check("ovf_err", 32'(io_bus.stk_err), 32'd1);
    io_bus.start = 1'b1;
    io_bus.instr_valid = 1'b1;
    repeat (4) @(negedge clk5m);
    check("err_hold", {io_bus.stk_err, io_bus.instr_req, io_bus.en, io_bus.load}, 4'b1000);
    io_bus.start = 1'b0;
    io_bus.instr_valid = 1'b0;
    do_reset();
    check("err_clr", {io_bus.en, io_bus.load, io_bus.data_in, io_bus.instr_req, io_bus.halted, io_bus.stk_err}, 32'd0);
    set_pc(10'd7);
    pulse_start();
    issue(4'd5, 10'h0, 1'b0);
    @(negedge clk5m);
    check("skip2_pre", 32'(io_bus.en), 32'd1);
    rst = 1'b1;
    @(negedge clk5m);
    check("rst_skip2", {io_bus.en, io_bus.instr_req, io_bus.halted, io_bus.stk_err}, 4'b0000);
    rst = 1'b0;
    @(negedge clk5m);
    set_pc(AW'($urandom));
    pulse_start();
    for (int i = 0; i < 250; i++) begin
      if (io_bus.stk_err) begin
        do_reset();
        set_pc(AW'($urandom));
        pulse_start();
      end else if (io_bus.halted) pulse_start();
      repeat ($urandom_range(0, 2)) begin
        io_bus.opcode = 4'($urandom);
        @(negedge clk5m);
      end
      issue(4'($urandom_range(0, 15)), AW'($urandom), 1'($urandom));
      for (int k = 0; k < 4 && !(io_bus.instr_req || io_bus.halted || io_bus.stk_err); k++) @(negedge clk5m);
    end
    repeat (3) @(negedge clk5m);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
